// File: rtl/ibex_mem_resp_model.sv
// Slave-side responder for the Ibex req/gnt/rvalid memory protocol.
// Ports: clk_i/rst_ni; req_i, gnt_o, addr_i, we_i, be_i, wdata_i in;
//        rvalid_o, rdata_o, err_o, outstanding_o out.
module ibex_mem_resp_model #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW = 10,
    parameter int MAX_OUTSTANDING = 4,
    parameter int GNT_DELAY = 0,
    parameter int RVALID_DELAY = 1,
    parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_BASE = '0,
    parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_MASK = '0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [ADDR_WIDTH-1:0]                  addr_i,
    input  logic                                   we_i,
    input  logic [DATA_WIDTH/8-1:0]                be_i,
    input  logic [DATA_WIDTH-1:0]                  wdata_i,
    output logic                                   rvalid_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int DEPTH = 2 ** MEM_AW;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int LCW = (RVALID_DELAY > 1) ? $clog2(RVALID_DELAY) : 1;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [MAX_OUTSTANDING-1:0] q_we;
    logic [MAX_OUTSTANDING-1:0] q_err;
    logic [DATA_WIDTH-1:0]      q_data [MAX_OUTSTANDING];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic [LCW-1:0]             lat;

    logic [MEM_AW-1:0]     idx;
    logic                  acc_err;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  head_vld;
    logic                  load_lat;
    logic [DATA_WIDTH-1:0] rd_cap;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx      = addr_i[OFF +: MEM_AW];
    assign acc_err  = (ERR_ADDR_MASK != '0) &&
                      ((addr_i & ERR_ADDR_MASK) == ERR_ADDR_BASE);
    // full comes from the registered count, so a pop this cycle
    // cannot make room for a grant in the same cycle
    assign full     = (count == CW'(MAX_OUTSTANDING));
    assign push     = req_i && gnt_o;
    assign head_vld = (count != '0);
    assign rvalid_o = head_vld && (lat == '0);
    assign pop      = rvalid_o;
    // a new head arrives either into an empty queue or via promotion
    assign load_lat = (push && (count == '0)) ||
                      (pop && ((count > CW'(1)) || push));
    assign rd_cap   = (acc_err || we_i) ? '0 : mem[idx];

    assign rdata_o       = (rvalid_o && !q_we[rd_ptr]) ? q_data[rd_ptr] : '0;
    assign err_o         = rvalid_o && q_err[rd_ptr];
    assign outstanding_o = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && we_i && !acc_err) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_we   <= '0;
            q_err  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) q_data[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lat    <= '0;
        end else begin
            if (push) begin
                q_we[wr_ptr]   <= we_i;
                q_err[wr_ptr]  <= acc_err;
                q_data[wr_ptr] <= rd_cap;
                wr_ptr         <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (load_lat) lat <= LCW'(RVALID_DELAY - 1);
            else if (head_vld && (lat != '0)) lat <= lat - 1'b1;
        end
    end

    if (GNT_DELAY == 0) begin : g_comb_gnt
        assign gnt_o = rst_ni && req_i && !full;
    end else begin : g_fsm_gnt
        localparam int GCW = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;
        localparam logic [GCW-1:0] RELOAD = GCW'(GNT_DELAY - 1);

        typedef enum logic {IDLE, WAIT} gstate_e;
        gstate_e        st_q, st_d;
        logic [GCW-1:0] cnt_q, cnt_d;
        logic           gnt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                st_q  <= IDLE;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            gnt   = 1'b0;
            unique case (st_q)
                IDLE: begin
                    if (req_i) begin
                        st_d  = WAIT;
                        cnt_d = RELOAD;
                    end
                end
                WAIT: begin
                    if (!req_i) begin
                        // request withdrawn before grant: start over
                        st_d  = IDLE;
                        cnt_d = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!full) begin
                        gnt   = 1'b1;
                        cnt_d = RELOAD;
                    end
                end
                default: st_d = IDLE;
            endcase
        end

        assign gnt_o = gnt;
    end

endmodule

// File: doc/ibex_mem_resp_model.md
Name: ibex_mem_resp_model

Overview:
- Synthesizable-style responder for the Ibex request/grant/rvalid memory protocol.
- Drives the slave side of one instruction or data port in DV benches and FPGA smoke tests.
- Adds behaviour the plain interface bundle lacks: configurable grant and response latency, multiple outstanding transactions, a byte-enabled backing store, and address-range error injection.
- Responses are strictly in order.

Parameters:
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- MEM_AW, 10: log2 of backing-store depth in words.
- MAX_OUTSTANDING, 4: granted-but-unanswered transaction limit; must be 1..16.
- GNT_DELAY, 0: cycles from request to grant. 0 means combinational grant.
- RVALID_DELAY, 1: cycles from head-of-queue to rvalid; must be at least 1.
- ERR_ADDR_BASE, 0: error-region match value.
- ERR_ADDR_MASK, 0: error-region mask. 0 disables error injection.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset; asynchronous, active-low.
- req_i, input, 1: request.
- gnt_o, output, 1: grant.
- addr_i, input, ADDR_WIDTH: byte address.
- we_i, input, 1: 1 = write.
- be_i, input, DATA_WIDTH/8: byte enables.
- wdata_i, input, DATA_WIDTH: write data.
- rvalid_o, output, 1: response valid.
- rdata_o, output, DATA_WIDTH: read data.
- err_o, output, 1: response error; valid only with rvalid_o.
- outstanding_o, output, $clog2(MAX_OUTSTANDING+1): current queue occupancy.

Behaviour:
- Reset (rst_ni low, async):
  - gnt_o, rvalid_o, err_o, rdata_o, outstanding_o = 0.
  - Queue empty, latency counters cleared, grant FSM in IDLE.
  - Backing store cleared to 0.
  - Reset mid-transaction discards all queued responses; no rvalid follows.
- Handshake:
  - A transaction is accepted in the cycle where req_i && gnt_o.
  - addr/we/be/wdata are sampled in that cycle.
  - gnt_o never asserts when outstanding_o == MAX_OUTSTANDING.
  - A pop in the same cycle does not free a slot for that cycle's grant.
- Grant FSM:
  - States: IDLE, WAIT.
  - GNT_DELAY = 0: gnt_o = req_i && !full, combinationally; FSM unused.
  - GNT_DELAY = N > 0:
    - IDLE -> WAIT on req_i; counter loads N-1.
    - WAIT decrements while req_i is held.
    - gnt_o asserts when the counter is 0 and the queue is not full. The first grant falls in cycle T+N, where T is the cycle req_i first seen.
    - After a grant: WAIT with reload if req_i stays high, else IDLE.
    - req_i dropped before grant (protocol violation, tolerated): return to IDLE; counter discarded.
  - When full, the FSM holds with the counter at 0; grant follows in the first non-full cycle.
- Address decode:
  - Word index = addr_i[$clog2(DATA_WIDTH/8) +: MEM_AW].
  - Upper bits are ignored, so addresses alias and wrap modulo 2^MEM_AW words.
  - err = (ERR_ADDR_MASK != 0) && ((addr_i & ERR_ADDR_MASK) == ERR_ADDR_BASE).
- On grant:
  - Write, no err: store bytes where be_i = 1; other bytes unchanged.
  - Read: data is captured from the store at grant time, after any write in the same cycle (impossible, one grant per cycle).
    - This gives read-after-write ordering in program order.
  - err: no store update; captured read data = 0.
  - Push {we, err, data} into the in-order queue.
- Response:
  - A latency counter loads RVALID_DELAY-1 when an entry becomes head (pushed into an empty queue, or promoted by a pop).
  - Entry granted into an empty queue in cycle T: rvalid_o in cycle T+RVALID_DELAY.
  - Queued entry: rvalid_o RVALID_DELAY cycles after its predecessor's rvalid.
  - rvalid_o is a single-cycle pulse per transaction. The entry pops in the same cycle.
  - With rvalid_o: rdata_o = captured data for reads, 0 for writes; err_o = entry err.
  - rdata_o and err_o are 0 when rvalid_o = 0.
- Simultaneous push and pop: occupancy unchanged; the pushed entry keeps its position; counter handling as above.
- outstanding_o is registered; it updates the cycle after push/pop.

Test Plan:
- GNT_DELAY=0, RVALID_DELAY=1: write 0xDEADBEEF to 0x100 (be=0xF), then read 0x100 -> gnt same cycle as req; rvalid one cycle after each grant; read rdata = 0xDEADBEEF, err_o = 0.
- Byte enables: write 0x11223344 (be=0xF), then 0xAABBCCDD (be=0x5) to 0x40, read 0x40 -> rdata = 0x11BB33DD.
- MAX_OUTSTANDING=4, RVALID_DELAY=5, req held continuously -> four grants on consecutive cycles, gnt_o low while outstanding_o = 4, rvalids spaced 5 cycles apart in order; grant resumes the cycle after the first pop.
- GNT_DELAY=3: req rises at cycle 10 -> gnt_o at cycle 13; req dropped at cycle 11 -> no grant, FSM back to IDLE.
- ERR_ADDR_BASE=0x8000_0000, ERR_ADDR_MASK=0xF000_0000: write to 0x8000_0010, then read 0x8000_0010 and alias 0x0000_0010 (MEM_AW=10) -> err_o = 1 on both 0x8000_0010 responses, read rdata = 0; aliased location unchanged (0).
- Reset: assert rst_ni low with 3 transactions outstanding -> all outputs 0 immediately; no rvalid after release; a post-reset read of a previously written address returns 0.
